// File: rtl/video_mnist_pkg.sv
// Shared register map for the MNIST video parameter block.
// Both the parameter writer (Wishbone master) and the register slave use
// these addresses and the mode field width.
package video_mnist_pkg;

   localparam int VM_MODE_WIDTH = 3;
   localparam int VM_ADR_MODE   = 0;
   localparam int VM_ADR_TH     = 1;

   typedef logic [VM_MODE_WIDTH-1:0] vm_mode_t;

endpackage

// File: rtl/video_mnist_param_writer.sv
// Wishbone master that pushes one {mode, threshold} command into the MNIST
// parameter registers. It can optionally read both registers back and
// compare them with what was written. Each access is bounded by a wait
// timeout.
//
// Ports
//   m_wb_rst_i, m_wb_clk_i         synchronous active-high reset, clock
//   s_param_mode/th/valid/ready    command input, accepted only when idle
//   m_wb_adr_o/dat_o/we_o/sel_o/stb_o, m_wb_dat_i/ack_i
//                                  Wishbone master (ack may be combinational)
//   busy, done                     command in progress, one-cycle finish pulse
//   err_timeout, err_verify        sticky status, cleared by the next command
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | ready for a command, no bus activity
// WR_MODE | writing mode to ADR_MODE
// WR_TH   | writing threshold to ADR_TH
// RD_MODE | reading back ADR_MODE, compare with mode
// RD_TH   | reading back ADR_TH, compare with threshold
module video_mnist_param_writer
   import video_mnist_pkg::*;
#(
   parameter int WB_ADR_WIDTH = 8,
   parameter int WB_DAT_WIDTH = 32,
   parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
   parameter int TCOUNT_WIDTH = 4,
   parameter int ADR_MODE     = VM_ADR_MODE,
   parameter int ADR_TH       = VM_ADR_TH,
   parameter int VERIFY       = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic                    m_wb_rst_i,
   input  logic                    m_wb_clk_i,
   input  vm_mode_t                s_param_mode,
   input  logic [TCOUNT_WIDTH-1:0] s_param_th,
   input  logic                    s_param_valid,
   output logic                    s_param_ready,
   output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
   output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
   output logic                    m_wb_we_o,
   output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
   output logic                    m_wb_stb_o,
   input  logic                    m_wb_ack_i,
   output logic                    busy,
   output logic                    done,
   output logic                    err_timeout,
   output logic                    err_verify
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_MODE = 3'd1;
   localparam logic [2:0] S_WR_TH   = 3'd2;
   localparam logic [2:0] S_RD_MODE = 3'd3;
   localparam logic [2:0] S_RD_TH   = 3'd4;

   // Wait counter runs 0..TIMEOUT-1 while stb is high without ack.
   localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic [2:0]              r_state,  w_state;
   logic                    r_stb,    w_stb;
   logic                    r_we,     w_we;
   logic [WB_ADR_WIDTH-1:0] r_adr,    w_adr;
   logic [WB_DAT_WIDTH-1:0] r_dat,    w_dat;
   logic                    r_busy,   w_busy;
   logic                    r_done,   w_done;
   logic                    r_ready,  w_ready;
   logic                    r_err_to, w_err_to;
   logic                    r_err_vf, w_err_vf;
   vm_mode_t                r_mode,   w_mode;
   logic [TCOUNT_WIDTH-1:0] r_th,     w_th;
   logic [WAIT_W-1:0]       r_wait,   w_wait;
   logic                    w_acked;
   logic                    w_finish;
   logic                    w_unused_dat;

   // Only the low field bits are compared on read-back.
   assign w_unused_dat = ^m_wb_dat_i;

   // An ack outside stb never completes an access.
   assign w_acked = r_stb && m_wb_ack_i;

   always_comb begin
      w_state  = r_state;
      w_stb    = r_stb;
      w_we     = r_we;
      w_adr    = r_adr;
      w_dat    = r_dat;
      w_busy   = r_busy;
      w_done   = 1'b0;
      w_ready  = r_ready;
      w_err_to = r_err_to;
      w_err_vf = r_err_vf;
      w_mode   = r_mode;
      w_th     = r_th;
      w_wait   = r_wait;
      w_finish = 1'b0;

      if (r_state == S_IDLE) begin
         if (s_param_valid && r_ready) begin
            w_mode   = s_param_mode;
            w_th     = s_param_th;
            w_err_to = 1'b0;
            w_err_vf = 1'b0;
            w_ready  = 1'b0;
            w_busy   = 1'b1;
            w_state  = S_WR_MODE;
            w_stb    = 1'b1;
            w_we     = 1'b1;
            w_adr    = WB_ADR_WIDTH'(ADR_MODE);
            w_dat    = WB_DAT_WIDTH'(s_param_mode);
            w_wait   = '0;
         end
      end else if (w_acked) begin
         // Next access is presented straight away, stb stays high.
         w_wait = '0;
         case (r_state)
            S_WR_MODE: begin
               w_state = S_WR_TH;
               w_we    = 1'b1;
               w_adr   = WB_ADR_WIDTH'(ADR_TH);
               w_dat   = WB_DAT_WIDTH'(r_th);
            end
            S_WR_TH: begin
               if (VERIFY != 0) begin
                  w_state = S_RD_MODE;
                  w_we    = 1'b0;
                  w_adr   = WB_ADR_WIDTH'(ADR_MODE);
                  w_dat   = '0;
               end else begin
                  w_finish = 1'b1;
               end
            end
            S_RD_MODE: begin
               if (m_wb_dat_i[VM_MODE_WIDTH-1:0] != r_mode) w_err_vf = 1'b1;
               w_state = S_RD_TH;
               w_we    = 1'b0;
               w_adr   = WB_ADR_WIDTH'(ADR_TH);
               w_dat   = '0;
            end
            S_RD_TH: begin
               if (m_wb_dat_i[TCOUNT_WIDTH-1:0] != r_th) w_err_vf = 1'b1;
               w_finish = 1'b1;
            end
            default: w_finish = 1'b1;
         endcase
      end else if (r_wait == WAIT_LAST) begin
         w_err_to = 1'b1;
         w_finish = 1'b1;
      end else begin
         w_wait = r_wait + 1'b1;
      end

      if (w_finish) begin
         w_state = S_IDLE;
         w_stb   = 1'b0;
         w_we    = 1'b0;
         w_adr   = '0;
         w_dat   = '0;
         w_busy  = 1'b0;
         w_done  = 1'b1;
         w_ready = 1'b1;
         w_wait  = '0;
      end
   end

   always_ff @(posedge m_wb_clk_i) begin
      if (m_wb_rst_i) begin
         r_state  <= S_IDLE;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_adr    <= '0;
         r_dat    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
         r_err_to <= 1'b0;
         r_err_vf <= 1'b0;
         r_mode   <= '0;
         r_th     <= '0;
         r_wait   <= '0;
      end else begin
         r_state  <= w_state;
         r_stb    <= w_stb;
         r_we     <= w_we;
         r_adr    <= w_adr;
         r_dat    <= w_dat;
         r_busy   <= w_busy;
         r_done   <= w_done;
         r_ready  <= w_ready;
         r_err_to <= w_err_to;
         r_err_vf <= w_err_vf;
         r_mode   <= w_mode;
         r_th     <= w_th;
         r_wait   <= w_wait;
      end
   end

   assign s_param_ready = r_ready;
   assign m_wb_adr_o    = r_adr;
   assign m_wb_dat_o    = r_dat;
   assign m_wb_we_o     = r_we;
   assign m_wb_sel_o    = '1;
   assign m_wb_stb_o    = r_stb;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err_timeout   = r_err_to;
   assign err_verify    = r_err_vf;

endmodule

// File: tb/tb_video_mnist_param_writer.sv
// Bench for video_mnist_param_writer. Two instances share clock and reset:
// index 0 reads back (VERIFY=1), index 1 only writes (VERIFY=0). Both use
// TIMEOUT=8. A behavioural register slave with programmable ack latency,
// never-ack and threshold-corruption sits on each bus. The driver pushes the
// expected accesses and the command outcome into queues. The monitor pops
// them when the bus acks or when done pulses.
module tb_video_mnist_param_writer;

   localparam int TO = 8;

   typedef struct {
      bit          we;
      int          adr;
      logic [31:0] dat;
   } acc_t;

   typedef struct {
      int stb_cyc;
      int lat;
      bit ev;
      bit et;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  p_mode  [2];
   logic [3:0]  p_th    [2];
   logic        p_valid [2];
   logic        p_ready [2];
   logic [7:0]  adr     [2];
   logic [31:0] dat_o   [2];
   logic [31:0] dat_i   [2];
   logic        we      [2];
   logic        stb     [2];
   logic        ack     [2];
   logic [3:0]  sel     [2];
   logic        busy    [2];
   logic        done    [2];
   logic        et      [2];
   logic        ev      [2];

   int          lat       [2];
   bit          never_ack [2];
   bit          corrupt   [2];
   int          scnt      [2];
   logic [31:0] mem       [2][2];

   acc_t acc_q[$];
   res_t res_q[$];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   video_mnist_param_writer #(.VERIFY(1), .TIMEOUT(TO)) dut_v (
      .m_wb_rst_i(rst), .m_wb_clk_i(clk),
      .s_param_mode(p_mode[0]), .s_param_th(p_th[0]),
      .s_param_valid(p_valid[0]), .s_param_ready(p_ready[0]),
      .m_wb_adr_o(adr[0]), .m_wb_dat_o(dat_o[0]), .m_wb_dat_i(dat_i[0]),
      .m_wb_we_o(we[0]), .m_wb_sel_o(sel[0]), .m_wb_stb_o(stb[0]),
      .m_wb_ack_i(ack[0]), .busy(busy[0]), .done(done[0]),
      .err_timeout(et[0]), .err_verify(ev[0]));

   video_mnist_param_writer #(.VERIFY(0), .TIMEOUT(TO)) dut_n (
      .m_wb_rst_i(rst), .m_wb_clk_i(clk),
      .s_param_mode(p_mode[1]), .s_param_th(p_th[1]),
      .s_param_valid(p_valid[1]), .s_param_ready(p_ready[1]),
      .m_wb_adr_o(adr[1]), .m_wb_dat_o(dat_o[1]), .m_wb_dat_i(dat_i[1]),
      .m_wb_we_o(we[1]), .m_wb_sel_o(sel[1]), .m_wb_stb_o(stb[1]),
      .m_wb_ack_i(ack[1]), .busy(busy[1]), .done(done[1]),
      .err_timeout(et[1]), .err_verify(ev[1]));

   // Register slave: ack after lat wait cycles, combinational when lat=0.
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         ack[d]   = stb[d] && !never_ack[d] && (scnt[d] == lat[d]);
         dat_i[d] = mem[d][adr[d][0]];
         if (corrupt[d] && adr[d] == 8'd1) dat_i[d] = dat_i[d] ^ 32'h1;
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (stb[d] && !ack[d]) scnt[d] <= scnt[d] + 1;
         else                   scnt[d] <= 0;
         if (stb[d] && ack[d] && we[d]) mem[d][adr[d][0]] <= dat_o[d];
      end
   end

   // Reference model: the access list and outcome follow from the command
   // and the slave behaviour alone.
   function automatic void push_expect(int d, logic [2:0] m, logic [3:0] t);
      acc_t a;
      res_t r;
      int   n;
      n = never_ack[d] ? 0 : ((d == 0) ? 4 : 2);
      if (n > 0) begin
         a.we = 1; a.adr = 0; a.dat = 32'(m); acc_q.push_back(a);
         a.we = 1; a.adr = 1; a.dat = 32'(t); acc_q.push_back(a);
      end
      if (n > 2) begin
         a.we = 0; a.adr = 0; a.dat = 0; acc_q.push_back(a);
         a.we = 0; a.adr = 1; a.dat = 0; acc_q.push_back(a);
      end
      r.stb_cyc = never_ack[d] ? TO : n * (lat[d] + 1);
      r.lat     = r.stb_cyc + 1;
      r.et      = never_ack[d];
      r.ev      = !never_ack[d] && (d == 0) && corrupt[d];
      res_q.push_back(r);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // Monitor
   bit          prev_rst = 0;
   bit          active   [2];
   bit          chk_acc  [2];
   bit          pwait    [2];
   bit          st_t     [2];
   bit          st_v     [2];
   int          cyc      [2];
   int          stb_cyc  [2];
   logic [7:0]  padr     [2];
   logic [31:0] pdat     [2];
   logic        pwe      [2];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            active[d]  = 0;
            chk_acc[d] = 0;
            st_t[d]    = 0;
            st_v[d]    = 0;
            if (prev_rst)
               chk("reset_state", {stb[d], we[d], adr[d], dat_o[d], busy[d],
                                   done[d], et[d], ev[d], p_ready[d]}, 64'd1);
            pwait[d] = 0;
         end else begin
            if (chk_acc[d]) begin
               chk("accept_out", {stb[d], we[d], busy[d], p_ready[d], et[d], ev[d]}, 6'b111000);
               chk_acc[d] = 0;
            end
            if (active[d]) begin
               cyc[d]++;
               if (stb[d]) stb_cyc[d]++;
               if (stb[d] && pwait[d])
                  chk("stb_hold", {adr[d], we[d], dat_o[d]}, {padr[d], pwe[d], pdat[d]});
               if (stb[d] && ack[d]) begin
                  if (acc_q.size() == 0) fail_now("unexpected_access");
                  else begin
                     acc_t a;
                     a = acc_q.pop_front();
                     chk("acc_we",  64'(we[d]),    64'(a.we));
                     chk("acc_adr", 64'(adr[d]),   64'(a.adr));
                     chk("acc_dat", 64'(dat_o[d]), 64'(a.dat));
                     chk("acc_sel", 64'(sel[d]),   64'hF);
                  end
               end
               if (done[d]) begin
                  if (res_q.size() == 0) fail_now("unexpected_done");
                  else begin
                     res_t r;
                     r = res_q.pop_front();
                     chk("latency",   64'(cyc[d]),     64'(r.lat));
                     chk("stb_cyc",   64'(stb_cyc[d]), 64'(r.stb_cyc));
                     chk("err_flags", {et[d], ev[d]},  {r.et, r.ev});
                     chk("done_out",  {stb[d], busy[d], p_ready[d]}, 3'b001);
                     chk("acc_left",  64'(acc_q.size()), 64'd0);
                     st_t[d] = r.et;
                     st_v[d] = r.ev;
                  end
                  active[d] = 0;
               end else if (cyc[d] > 200) begin
                  fail_now("watchdog_no_done");
                  active[d] = 0;
               end
            end else begin
               chk("idle_out", {p_ready[d], busy[d], stb[d], done[d]}, 4'b1000);
               if (p_valid[d] && p_ready[d]) begin
                  chk("sticky_flags", {et[d], ev[d]}, {st_t[d], st_v[d]});
                  active[d]  = 1;
                  chk_acc[d] = 1;
                  cyc[d]     = 0;
                  stb_cyc[d] = 0;
               end
            end
            pwait[d] = stb[d] && !ack[d];
            padr[d]  = adr[d];
            pdat[d]  = dat_o[d];
            pwe[d]   = we[d];
         end
      end
      prev_rst = rst;
   end

   // Driver
   task automatic start_cmd(input int d, input logic [2:0] m, input logic [3:0] t, input int hold);
      bit acc_ok;
      acc_ok = 0;
      @(posedge clk); #1;
      p_mode[d]  = m;
      p_th[d]    = t;
      p_valid[d] = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (p_ready[d]) begin
            acc_ok = 1;
            break;
         end
      end
      if (acc_ok) push_expect(d, m, t);
      @(posedge clk); #1;
      // Keep valid high with changing fields while busy; it must be ignored.
      for (int i = 0; i < hold; i++) begin
         p_mode[d] = 3'($urandom);
         p_th[d]   = 4'($urandom);
         @(posedge clk); #1;
      end
      p_valid[d] = 0;
   endtask

   task automatic wait_done(input int d);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done[d]) break;
      end
      @(posedge clk); #1;
   endtask

   task automatic set_slave(input int d, input int l, input bit na, input bit cr);
      lat[d]       = l;
      never_ack[d] = na;
      corrupt[d]   = cr;
   endtask

   initial begin
      rst = 1;
      for (int d = 0; d < 2; d++) begin
         p_valid[d] = 0;
         p_mode[d]  = 0;
         p_th[d]    = 0;
         set_slave(d, 0, 0, 0);
      end
      repeat (3) @(posedge clk);
      #1 rst = 0;

      set_slave(0, 0, 0, 0);
      start_cmd(0, 3'd2, 4'd5, 0);
      wait_done(0);

      set_slave(0, 0, 0, 1);
      start_cmd(0, 3'd2, 4'd5, 0);
      wait_done(0);
      set_slave(0, 1, 0, 0);
      start_cmd(0, 3'd6, 4'd9, 1);
      wait_done(0);

      set_slave(0, 0, 1, 0);
      start_cmd(0, 3'd3, 4'd12, 2);
      wait_done(0);
      set_slave(0, 0, 0, 0);
      start_cmd(0, 3'd7, 4'd15, 0);
      wait_done(0);

      set_slave(1, 3, 0, 0);
      start_cmd(1, 3'd5, 4'd10, 3);
      wait_done(1);
      set_slave(1, 0, 0, 0);
      start_cmd(1, 3'd1, 4'd0, 0);
      wait_done(1);

      set_slave(0, 3, 0, 0);
      start_cmd(0, 3'd4, 4'd6, 0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stb[0] && we[0] && adr[0] == 8'd1) break;
      end
      @(posedge clk); #1;
      rst = 1;
      acc_q.delete();
      res_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      set_slave(0, 0, 0, 0);
      start_cmd(0, 3'd1, 4'd3, 0);
      wait_done(0);

      for (int k = 0; k < 40; k++) begin
         int d;
         d = $urandom_range(0, 1);
         set_slave(d, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
         start_cmd(d, 3'($urandom), 4'($urandom), lat[d]);
         wait_done(d);
      end

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
